// File: rtl/prefetch_pkg.sv
// Shared types and widths for the instruction prefetch queue.
package prefetch_pkg;

   localparam int DEPTH_DEF = 8;
   localparam int ADDR_W    = 16;
   localparam int BYTE_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DROP = 2'd2
   } state_e;

endpackage

// File: rtl/pq_ring.sv
// Byte ring buffer with wrapping pointers, multi-byte pop and a 4-byte head window.
module pq_ring
   import prefetch_pkg::*;
#(
   parameter  int DEPTH = DEPTH_DEF,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush_i,
   input  logic                push_i,
   input  logic [BYTE_W-1:0]   push_data_i,
   input  logic                pop_i,
   input  logic [2:0]          pop_n_i,
   output logic [CW-1:0]       count_o,
   output logic [4*BYTE_W-1:0] window_o
);

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]     cnt_q, cnt_d;

   always_comb begin
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (flush_i) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push_i) wr_d = wr_q + AW'(1);
         if (pop_i)  rd_d = rd_q + AW'(pop_n_i);
         cnt_d = cnt_q + CW'(push_i) - (pop_i ? CW'(pop_n_i) : '0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i && !flush_i) mem_q[wr_q] <= push_data_i;
   end

   // Lanes past the fill level read as zero so stale storage never leaks out.
   always_comb begin
      window_o = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (CW'(i) < cnt_q) window_o[i*BYTE_W +: BYTE_W] = mem_q[rd_q + AW'(i)];
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetch FSM, redirect/drop handling, head window.
// Optional sticky illegal-take flag `err` when PREFETCH_ERR_EN is defined.
module prefetch_queue
   import prefetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                clk,
   input  logic                rst,
   output logic [ADDR_W-1:0]   fa,
   output logic                frd,
   input  logic                fack,
   input  logic [BYTE_W-1:0]   fd,
   input  logic                redir,
   input  logic [ADDR_W-1:0]   ra,
   input  logic                take,
   input  logic [1:0]          len,
   output logic [4*BYTE_W-1:0] raw,
   output logic [2:0]          avail,
   output logic [ADDR_W-1:0]   ao
`ifdef PREFETCH_ERR_EN
   ,
   output logic                err
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] fa_q, fa_d, ao_q, ao_d, tgt_q, tgt_d;
   logic [CW-1:0]     count, count_nxt;
   logic [2:0]        take_n;
   logic              ack, legal, push, pop;

   assign take_n    = {1'b0, len} + 3'd1;
   // Gated by rst so the request drops the instant reset asserts mid-transfer.
   assign frd       = rst && (state_q != ST_IDLE);
   assign ack       = fack && frd;
   assign legal     = take && (CW'(take_n) <= count);
   assign push      = ack && !redir && (state_q == ST_REQ);
   assign pop       = legal && !redir;
   assign count_nxt = count + CW'(push) - (pop ? CW'(take_n) : '0);

   pq_ring #(.DEPTH(DEPTH)) u_ring (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (redir),
      .push_i      (push),
      .push_data_i (fd),
      .pop_i       (pop),
      .pop_n_i     (take_n),
      .count_o     (count),
      .window_o    (raw)
   );

   always_comb begin
      state_d = state_q;
      fa_d    = fa_q;
      ao_d    = ao_q;
      tgt_d   = tgt_q;
      if (redir) begin
         ao_d  = ra;
         tgt_d = ra;
         // An unacknowledged request is still in flight: wait it out in DROP.
         if (frd && !ack) begin
            state_d = ST_DROP;
         end else begin
            state_d = ST_REQ;
            fa_d    = ra;
         end
      end else begin
         if (pop) ao_d = ao_q + ADDR_W'(take_n);
         case (state_q)
            ST_IDLE: if (pop || count < CW'(DEPTH)) state_d = ST_REQ;
            ST_REQ: if (ack) begin
               fa_d = fa_q + ADDR_W'(1);
               if (count_nxt == CW'(DEPTH)) state_d = ST_IDLE;
            end
            ST_DROP: if (ack) begin
               fa_d    = tgt_q;
               state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_REQ;
         fa_q    <= '0;
         ao_q    <= '0;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         fa_q    <= fa_d;
         ao_q    <= ao_d;
         tgt_q   <= tgt_d;
      end
   end

   assign fa    = fa_q;
   assign ao    = ao_q;
   assign avail = (count >= CW'(4)) ? 3'd4 : 3'(count);

`ifdef PREFETCH_ERR_EN
   logic err_q, err_d;

   assign err_d = redir ? 1'b0 : (err_q || (take && !legal));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) err_q <= 1'b0;
      else      err_q <= err_d;
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue against a byte-queue reference model.
module tb_prefetch_queue;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] fa, ra, ao;
   logic        frd, fack, redir, take;
   logic [7:0]  fd;
   logic [1:0]  len;
   logic [31:0] raw;
   logic [2:0]  avail;
`ifdef PREFETCH_ERR_EN
   logic        err;
`endif

   int checks = 0;
   int errors = 0;

   byte unsigned mq[$];
   logic [15:0]  m_fa, m_ao, m_tgt;
   bit           m_drop, m_err;

   prefetch_queue #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .fa    (fa),
      .frd   (frd),
      .fack  (fack),
      .fd    (fd),
      .redir (redir),
      .ra    (ra),
      .take  (take),
      .len   (len),
      .raw   (raw),
      .avail (avail),
      .ao    (ao)
`ifdef PREFETCH_ERR_EN
      ,
      .err   (err)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] exp_raw();
      logic [31:0] r = '0;
      for (int i = 0; i < 4; i++) if (i < mq.size()) r[i*8 +: 8] = mq[i];
      return r;
   endfunction

   function automatic logic [2:0] exp_avail();
      return (mq.size() >= 4) ? 3'd4 : 3'(mq.size());
   endfunction

   function automatic logic exp_frd();
      return mq.size() < DEPTH;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_fa = '0; m_ao = '0; m_tgt = '0; m_drop = 1'b0; m_err = 1'b0;
   endtask

   task automatic model_step(input bit r, input logic [15:0] a, input bit t,
                             input logic [1:0] l, input bit fk, input logic [7:0] d);
      bit ack, legal;
      int n;
      ack = fk && exp_frd();
      n   = int'(l) + 1;
      if (r) begin
         if (exp_frd() && !ack) begin m_drop = 1'b1; m_tgt = a; end
         else begin m_drop = 1'b0; m_fa = a; end
         mq.delete();
         m_ao  = a;
         m_err = 1'b0;
      end else begin
         legal = t && (n <= mq.size());
         if (t && !legal) m_err = 1'b1;
         if (legal) begin
            repeat (n) void'(mq.pop_front());
            m_ao = m_ao + 16'(n);
         end
         if (ack) begin
            if (m_drop) begin m_drop = 1'b0; m_fa = m_tgt; end
            else begin mq.push_back(d); m_fa = m_fa + 16'd1; end
         end
      end
   endtask

   task automatic cycle(input bit r, input logic [15:0] a, input bit t,
                        input logic [1:0] l, input bit fk, input logic [7:0] d);
      redir = r; ra = a; take = t; len = l; fack = fk; fd = d;
      @(posedge clk);
      model_step(r, a, t, l, fk, d);
      @(negedge clk);
      redir = 1'b0; take = 1'b0; fack = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b0; redir = 1'b0; take = 1'b0; fack = 1'b0;
      ra = '0; len = '0; fd = '0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0; redir = 1'b0; take = 1'b0; fack = 1'b0; ra = '0; len = '0; fd = '0;
      repeat (2) @(negedge clk);
      checks++; if (frd !== 1'b0) begin errors++; $display("FAIL reset_frd: got %0h expected 0", frd); end
      checks++; if (fa !== 16'h0000) begin errors++; $display("FAIL reset_fa: got %h expected 0000", fa); end
      checks++; if (ao !== 16'h0000) begin errors++; $display("FAIL reset_ao: got %h expected 0000", ao); end
      checks++; if (avail !== 3'd0) begin errors++; $display("FAIL reset_avail: got %0d expected 0", avail); end
      checks++; if (raw !== 32'h0) begin errors++; $display("FAIL reset_raw: got %h expected 00000000", raw); end
      fack = 1'b1; fd = 8'h99;
      @(negedge clk);
      fack = 1'b0;
      checks++; if (avail !== 3'd0) begin errors++; $display("FAIL reset_late_ack: avail got %0d expected 0", avail); end
      model_reset();
      rst = 1'b1;
      #1;
      checks++; if (frd !== 1'b1 || fa !== 16'h0000) begin
         errors++; $display("FAIL release_req: frd=%0h fa=%h expected frd=1 fa=0000", frd, fa);
      end
      cycle(0, '0, 0, 0, 1, 8'h11);
      cycle(0, '0, 0, 0, 1, 8'h22);
      cycle(0, '0, 0, 0, 1, 8'h33);
      cycle(0, '0, 0, 0, 1, 8'h44);
      checks++; if (avail !== 3'd4) begin errors++; $display("FAIL first4_avail: got %0d expected 4", avail); end
      checks++; if (raw !== 32'h44332211) begin errors++; $display("FAIL first4_raw: got %h expected 44332211", raw); end
      checks++; if (ao !== 16'h0000) begin errors++; $display("FAIL first4_ao: got %h expected 0000", ao); end
      checks++; if (fa !== 16'h0004) begin errors++; $display("FAIL first4_fa: got %h expected 0004", fa); end
   endtask

   task automatic test_full();
      logic [31:0] snap;
      apply_reset();
      for (int i = 0; i < DEPTH; i++) cycle(0, '0, 0, 0, 1, 8'($urandom));
      checks++; if (frd !== 1'b0) begin errors++; $display("FAIL full_frd: got %0h expected 0", frd); end
      checks++; if (fa !== 16'(DEPTH)) begin errors++; $display("FAIL full_fa: got %h expected %h", fa, 16'(DEPTH)); end
      snap = exp_raw();
      cycle(0, '0, 0, 0, 1, 8'hEE);
      checks++; if (raw !== snap || fa !== 16'(DEPTH)) begin
         errors++; $display("FAIL full_ack_ignored: raw=%h fa=%h expected raw=%h fa=%h", raw, fa, snap, 16'(DEPTH));
      end
      cycle(0, '0, 1, 0, 0, 8'h00);
      checks++; if (frd !== 1'b1) begin errors++; $display("FAIL full_resume_frd: got %0h expected 1", frd); end
      checks++; if (ao !== 16'h0001) begin errors++; $display("FAIL full_resume_ao: got %h expected 0001", ao); end
   endtask

   task automatic test_simultaneous();
      apply_reset();
      cycle(0, '0, 0, 0, 1, 8'hA0);
      cycle(0, '0, 0, 0, 1, 8'hA1);
      cycle(0, '0, 0, 0, 1, 8'hA2);
      cycle(0, '0, 1, 2'd1, 1, 8'hA3);
      checks++; if (avail !== 3'd2) begin errors++; $display("FAIL simul_avail: got %0d expected 2", avail); end
      checks++; if (ao !== 16'h0002) begin errors++; $display("FAIL simul_ao: got %h expected 0002", ao); end
      checks++; if (raw !== 32'h0000A3A2) begin errors++; $display("FAIL simul_raw: got %h expected 0000a3a2", raw); end
   endtask

   task automatic test_redirect();
      apply_reset();
      cycle(0, '0, 0, 0, 1, 8'h01);
      cycle(0, '0, 0, 0, 1, 8'h02);
      cycle(1, 16'h8000, 0, 0, 0, 8'h00);
      checks++; if (frd !== 1'b1 || fa !== 16'h0002) begin
         errors++; $display("FAIL drop_hold: frd=%0h fa=%h expected frd=1 fa=0002", frd, fa);
      end
      checks++; if (avail !== 3'd0 || ao !== 16'h8000) begin
         errors++; $display("FAIL drop_flush: avail=%0d ao=%h expected avail=0 ao=8000", avail, ao);
      end
      cycle(0, '0, 0, 0, 0, 8'h00);
      cycle(0, '0, 0, 0, 1, 8'hAA);
      checks++; if (frd !== 1'b1 || fa !== 16'h8000 || avail !== 3'd0) begin
         errors++; $display("FAIL drop_done: frd=%0h fa=%h avail=%0d expected frd=1 fa=8000 avail=0", frd, fa, avail);
      end
      cycle(0, '0, 0, 0, 1, 8'h55);
      checks++; if (raw !== 32'h00000055 || fa !== 16'h8001) begin
         errors++; $display("FAIL redir_first: raw=%h fa=%h expected raw=00000055 fa=8001", raw, fa);
      end
      apply_reset();
      cycle(1, 16'h4000, 0, 0, 0, 8'h00);
      cycle(1, 16'h5000, 0, 0, 0, 8'h00);
      checks++; if (fa !== 16'h0000 || ao !== 16'h5000) begin
         errors++; $display("FAIL drop_reredir: fa=%h ao=%h expected fa=0000 ao=5000", fa, ao);
      end
      cycle(0, '0, 0, 0, 1, 8'hBB);
      checks++; if (fa !== 16'h5000 || avail !== 3'd0) begin
         errors++; $display("FAIL drop_reredir_done: fa=%h avail=%0d expected fa=5000 avail=0", fa, avail);
      end
   endtask

   task automatic test_wrap_illegal();
      apply_reset();
      cycle(1, 16'hFFFF, 0, 0, 1, 8'h77);
      checks++; if (fa !== 16'hFFFF || avail !== 3'd0) begin
         errors++; $display("FAIL redir_ack: fa=%h avail=%0d expected fa=ffff avail=0", fa, avail);
      end
      cycle(0, '0, 0, 0, 1, 8'h01);
      cycle(0, '0, 0, 0, 1, 8'h02);
      checks++; if (fa !== 16'h0001) begin errors++; $display("FAIL wrap_fa: got %h expected 0001", fa); end
      cycle(0, '0, 1, 2'd3, 0, 8'h00);
      checks++; if (avail !== 3'd2 || ao !== 16'hFFFF) begin
         errors++; $display("FAIL illegal_take: avail=%0d ao=%h expected avail=2 ao=ffff", avail, ao);
      end
`ifdef PREFETCH_ERR_EN
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %0h expected 1", err); end
`endif
      cycle(0, '0, 1, 2'd1, 0, 8'h00);
      checks++; if (ao !== 16'h0001 || avail !== 3'd0) begin
         errors++; $display("FAIL wrap_ao: ao=%h avail=%0d expected ao=0001 avail=0", ao, avail);
      end
`ifdef PREFETCH_ERR_EN
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0h expected 1", err); end
      cycle(1, 16'h1234, 0, 0, 0, 8'h00);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %0h expected 0", err); end
`endif
   endtask

   task automatic test_random();
      apply_reset();
      for (int c = 0; c < 3000; c++) begin
         cycle($urandom_range(0, 99) < 4, 16'($urandom), $urandom_range(0, 99) < 45,
               2'($urandom_range(0, 3)), $urandom_range(0, 99) < 60, 8'($urandom));
         checks++; if (frd !== exp_frd()) begin
            errors++; $display("FAIL rnd_frd c=%0d: got %0h expected %0h", c, frd, exp_frd());
         end
         checks++; if (fa !== m_fa) begin
            errors++; $display("FAIL rnd_fa c=%0d: got %h expected %h", c, fa, m_fa);
         end
         checks++; if (ao !== m_ao) begin
            errors++; $display("FAIL rnd_ao c=%0d: got %h expected %h", c, ao, m_ao);
         end
         checks++; if (avail !== exp_avail()) begin
            errors++; $display("FAIL rnd_avail c=%0d: got %0d expected %0d", c, avail, exp_avail());
         end
         checks++; if (raw !== exp_raw()) begin
            errors++; $display("FAIL rnd_raw c=%0d: got %h expected %h", c, raw, exp_raw());
         end
`ifdef PREFETCH_ERR_EN
         checks++; if (err !== m_err) begin
            errors++; $display("FAIL rnd_err c=%0d: got %0h expected %0h", c, err, m_err);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_full();
      test_simultaneous();
      test_redirect();
      test_wrap_illegal();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
